// File: rtl/multimode_counter.sv
// Parametrised up/down counter with wrap or saturate bounds, terminal-count pulse,
// wrap tally and a sticky done flag that can end a simulation run.
module multimode_counter #(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned MAX          = 15,
    parameter int unsigned STEP         = 1,
    parameter bit          SATURATE     = 1'b0,
    parameter int unsigned WRAP_W       = 8,
    parameter int unsigned FINISH_WRAPS = 0,
    parameter bit          VERBOSE      = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              up,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic [WRAP_W-1:0] wraps,
    output logic              done
);

    // Bound arithmetic is one bit wider than the count so count+STEP cannot overflow.
    localparam logic [WIDTH:0]    MAX_X    = (WIDTH+1)'(MAX);
    localparam logic [WIDTH:0]    STEP_X   = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]    MOD_X    = MAX_X + 1'b1;
    localparam logic [WIDTH-1:0]  MAX_W    = WIDTH'(MAX);
    localparam logic [WIDTH-1:0]  STEP_W   = WIDTH'(STEP);
    localparam logic [WIDTH-1:0]  HALF_W   = WIDTH'(MAX / 2);
    localparam logic [WRAP_W-1:0] FINISH_W = WRAP_W'(FINISH_WRAPS);

    logic [WIDTH:0]    sum;
    logic [WIDTH:0]    wrap_down;
    logic              boundary;
    logic [WIDTH-1:0]  count_next;
    logic              tc_next;
    logic [WRAP_W-1:0] wraps_next;
    logic              done_next;

    always_comb begin
        sum        = {1'b0, count} + STEP_X;
        wrap_down  = {1'b0, count} + MOD_X - STEP_X;
        boundary   = 1'b0;
        count_next = count;
        wraps_next = wraps;
        done_next  = done;
        if (!done) begin
            if (load) begin
                count_next = (load_val > MAX_W) ? MAX_W : load_val;
            end else if (en) begin
                if (up) begin
                    if (sum <= MAX_X) begin
                        count_next = WIDTH'(sum);
                    end else begin
                        boundary   = 1'b1;
                        count_next = SATURATE ? MAX_W : WIDTH'(sum - MOD_X);
                    end
                end else begin
                    if ({1'b0, count} >= STEP_X) begin
                        count_next = count - STEP_W;
                    end else begin
                        boundary   = 1'b1;
                        count_next = SATURATE ? '0 : WIDTH'(wrap_down);
                    end
                end
            end
        end
        tc_next = boundary;
        // Only wrap-mode boundaries are tallied, and only they can raise done.
        if (boundary && !SATURATE) begin
            wraps_next = wraps + 1'b1;
            if ((FINISH_WRAPS != 0) && (wraps_next == FINISH_W)) begin
                done_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            tc    <= 1'b0;
            wraps <= '0;
            done  <= 1'b0;
        end else begin
            count <= count_next;
            tc    <= tc_next;
            wraps <= wraps_next;
            done  <= done_next;
        end
    end

`ifndef SYNTHESIS
    initial begin
        if (WIDTH < 2 || WIDTH > 32)
            $error("multimode_counter: WIDTH %0d out of range", WIDTH);
        if (MAX < 1 || (WIDTH < 32 && MAX > (32'd1 << WIDTH) - 32'd1))
            $error("multimode_counter: MAX %0d out of range", MAX);
        if (STEP < 1 || STEP > MAX)
            $error("multimode_counter: STEP %0d out of range", STEP);
    end

    always @(posedge clk) begin
        if (!rst && !done && (count_next != count)) begin
            if (VERBOSE)
                $display("Count: %d (0x%h)", count_next, count_next);
            if (count_next == HALF_W)
                $display("Halfway point reached!");
        end
    end

    // Triggered after the state update so the reported tally is the final one.
    always @(posedge done) begin
        $display("Counter complete after %0d wraps", wraps);
        $finish;
    end
`endif

endmodule

// File: tb/tb_multimode_counter.sv
// Directed self-checking bench for multimode_counter across wrap, saturate and done configurations.
module tb_multimode_counter;

    logic clk;
    int   vectors;
    int   miscompares;
    int   edges3;
    bit   done_started;

    logic rst0, en0, up0, load0; logic [3:0] lv0; logic [3:0] count0; logic tc0; logic [7:0] wraps0; logic done0;
    logic rst1, en1, up1, load1; logic [3:0] lv1; logic [3:0] count1; logic tc1; logic [7:0] wraps1; logic done1;
    logic rst2, en2, up2, load2; logic [3:0] lv2; logic [3:0] count2; logic tc2; logic [7:0] wraps2; logic done2;
    logic rst3, en3, up3, load3; logic [3:0] lv3; logic [3:0] count3; logic tc3; logic [7:0] wraps3; logic done3;

    multimode_counter u0 (
        .clk(clk), .rst(rst0), .en(en0), .up(up0), .load(load0), .load_val(lv0),
        .count(count0), .tc(tc0), .wraps(wraps0), .done(done0)
    );

    multimode_counter #(.MAX(9), .STEP(3), .VERBOSE(1'b0)) u1 (
        .clk(clk), .rst(rst1), .en(en1), .up(up1), .load(load1), .load_val(lv1),
        .count(count1), .tc(tc1), .wraps(wraps1), .done(done1)
    );

    multimode_counter #(.MAX(12), .STEP(1), .SATURATE(1'b1), .VERBOSE(1'b0)) u2 (
        .clk(clk), .rst(rst2), .en(en2), .up(up2), .load(load2), .load_val(lv2),
        .count(count2), .tc(tc2), .wraps(wraps2), .done(done2)
    );

    multimode_counter #(.FINISH_WRAPS(2), .VERBOSE(1'b0)) u3 (
        .clk(clk), .rst(rst3), .en(en3), .up(up3), .load(load3), .load_val(lv3),
        .count(count3), .tc(tc3), .wraps(wraps3), .done(done3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
        #2;
        vectors++; if (count0 !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_count got %0d expected 0", count0); end
        vectors++; if (tc0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tc got %b expected 0", tc0); end
        vectors++; if (wraps0 !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_wraps got %0d expected 0", wraps0); end
        vectors++; if (done0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %b expected 0", done0); end
        vectors++; if (count1 !== 4'd0 || count2 !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_count_others got %0d/%0d expected 0/0", count1, count2); end
        #9;
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    endtask

    task automatic test_up_wrap();
        logic [3:0] exp_c;
        en0 = 1'b1; up0 = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            exp_c = 4'(i % 16);
            vectors++; if (count0 !== exp_c) begin miscompares++; $display("[TB] FAIL up_count[%0d] got %0d expected %0d", i, count0, exp_c); end
            vectors++; if (tc0 !== (i == 16)) begin miscompares++; $display("[TB] FAIL up_tc[%0d] got %b expected %b", i, tc0, (i == 16)); end
            vectors++; if (wraps0 !== ((i == 16) ? 8'd1 : 8'd0)) begin miscompares++; $display("[TB] FAIL up_wraps[%0d] got %0d", i, wraps0); end
        end
        en0 = 1'b0;
        tick();
        vectors++; if (count0 !== 4'd0 || tc0 !== 1'b0) begin miscompares++; $display("[TB] FAIL hold got count %0d tc %b expected 0 0", count0, tc0); end
    endtask

    task automatic test_async_reset();
        en0 = 1'b1;
        repeat (5) tick();
        en0 = 1'b0;
        vectors++; if (count0 !== 4'd5 || wraps0 !== 8'd1) begin miscompares++; $display("[TB] FAIL pre_reset got count %0d wraps %0d expected 5 1", count0, wraps0); end
        #3;
        rst0 = 1'b1;
        #1;
        vectors++; if (count0 !== 4'd0) begin miscompares++; $display("[TB] FAIL async_count got %0d expected 0", count0); end
        vectors++; if (wraps0 !== 8'd0 || tc0 !== 1'b0 || done0 !== 1'b0) begin miscompares++; $display("[TB] FAIL async_flags got wraps %0d tc %b done %b expected 0", wraps0, tc0, done0); end
        rst0 = 1'b0;
    endtask

    task automatic test_mod9_up();
        int exp_c[7] = '{3, 6, 9, 2, 5, 8, 1};
        int exp_t[7] = '{0, 0, 0, 1, 0, 0, 1};
        int exp_w[7] = '{0, 0, 0, 1, 1, 1, 2};
        en1 = 1'b1; up1 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            vectors++; if (count1 !== 4'(exp_c[i])) begin miscompares++; $display("[TB] FAIL mod9_up_count[%0d] got %0d expected %0d", i, count1, exp_c[i]); end
            vectors++; if (tc1 !== 1'(exp_t[i])) begin miscompares++; $display("[TB] FAIL mod9_up_tc[%0d] got %b expected %0d", i, tc1, exp_t[i]); end
            vectors++; if (wraps1 !== 8'(exp_w[i])) begin miscompares++; $display("[TB] FAIL mod9_up_wraps[%0d] got %0d expected %0d", i, wraps1, exp_w[i]); end
        end
        en1 = 1'b0;
    endtask

    task automatic test_mod9_down();
        int exp_c[3] = '{1, 8, 5};
        int exp_t[3] = '{0, 1, 0};
        int exp_w[3] = '{2, 3, 3};
        load1 = 1'b1; lv1 = 4'd4;
        tick();
        load1 = 1'b0;
        vectors++; if (count1 !== 4'd4 || tc1 !== 1'b0 || wraps1 !== 8'd2) begin miscompares++; $display("[TB] FAIL load4 got count %0d tc %b wraps %0d expected 4 0 2", count1, tc1, wraps1); end
        en1 = 1'b1; up1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (count1 !== 4'(exp_c[i])) begin miscompares++; $display("[TB] FAIL mod9_down_count[%0d] got %0d expected %0d", i, count1, exp_c[i]); end
            vectors++; if (tc1 !== 1'(exp_t[i])) begin miscompares++; $display("[TB] FAIL mod9_down_tc[%0d] got %b expected %0d", i, tc1, exp_t[i]); end
            vectors++; if (wraps1 !== 8'(exp_w[i])) begin miscompares++; $display("[TB] FAIL mod9_down_wraps[%0d] got %0d expected %0d", i, wraps1, exp_w[i]); end
        end
        en1 = 1'b0;
    endtask

    task automatic test_load();
        load1 = 1'b1; lv1 = 4'd13;
        tick();
        vectors++; if (count1 !== 4'd9 || tc1 !== 1'b0) begin miscompares++; $display("[TB] FAIL load_clamp got count %0d tc %b expected 9 0", count1, tc1); end
        lv1 = 4'd2; en1 = 1'b1; up1 = 1'b1;
        tick();
        vectors++; if (count1 !== 4'd2) begin miscompares++; $display("[TB] FAIL load_over_en got %0d expected 2", count1); end
        vectors++; if (wraps1 !== 8'd3 || tc1 !== 1'b0) begin miscompares++; $display("[TB] FAIL load_flags got wraps %0d tc %b expected 3 0", wraps1, tc1); end
        load1 = 1'b0;
        tick();
        vectors++; if (count1 !== 4'd5) begin miscompares++; $display("[TB] FAIL step_after_load got %0d expected 5", count1); end
        en1 = 1'b0;
    endtask

    task automatic test_saturate();
        int up_c[4]   = '{11, 12, 12, 12};
        int up_t[4]   = '{0, 0, 1, 1};
        int down_t[3] = '{0, 1, 1};
        load2 = 1'b1; lv2 = 4'd10;
        tick();
        load2 = 1'b0; en2 = 1'b1; up2 = 1'b1;
        vectors++; if (count2 !== 4'd10) begin miscompares++; $display("[TB] FAIL sat_load got %0d expected 10", count2); end
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++; if (count2 !== 4'(up_c[i])) begin miscompares++; $display("[TB] FAIL sat_up_count[%0d] got %0d expected %0d", i, count2, up_c[i]); end
            vectors++; if (tc2 !== 1'(up_t[i])) begin miscompares++; $display("[TB] FAIL sat_up_tc[%0d] got %b expected %0d", i, tc2, up_t[i]); end
        end
        load2 = 1'b1; lv2 = 4'd1;
        tick();
        load2 = 1'b0; up2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (count2 !== 4'd0) begin miscompares++; $display("[TB] FAIL sat_down_count[%0d] got %0d expected 0", i, count2); end
            vectors++; if (tc2 !== 1'(down_t[i])) begin miscompares++; $display("[TB] FAIL sat_down_tc[%0d] got %b expected %0d", i, tc2, down_t[i]); end
        end
        en2 = 1'b0;
        vectors++; if (wraps2 !== 8'd0) begin miscompares++; $display("[TB] FAIL sat_wraps got %0d expected 0", wraps2); end
    endtask

    task automatic test_done();
        bit seen;
        seen = 1'b0;
        done_started = 1'b1;
        rst3 = 1'b0; en3 = 1'b1; up3 = 1'b1;
        for (int e = 1; e <= 40 && !seen; e++) begin
            @(negedge clk);
            edges3 = e;
            tick();
            if (e == 16) begin
                vectors++; if (count3 !== 4'd0 || wraps3 !== 8'd1 || done3 !== 1'b0) begin miscompares++; $display("[TB] FAIL done_first_wrap got count %0d wraps %0d done %b expected 0 1 0", count3, wraps3, done3); end
            end
            if (e == 31) begin
                vectors++; if (count3 !== 4'd15 || done3 !== 1'b0) begin miscompares++; $display("[TB] FAIL done_early got count %0d done %b expected 15 0", count3, done3); end
            end
            seen = (done3 === 1'b1);
        end
        if (!seen) begin
            vectors++; miscompares++;
            $display("[TB] FAIL done_timeout got done %b after 40 edges expected 1", done3);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; edges3 = 0; done_started = 1'b0;
        rst0 = 1'b0; en0 = 1'b0; up0 = 1'b0; load0 = 1'b0; lv0 = '0;
        rst1 = 1'b0; en1 = 1'b0; up1 = 1'b0; load1 = 1'b0; lv1 = '0;
        rst2 = 1'b0; en2 = 1'b0; up2 = 1'b0; load2 = 1'b0; lv2 = '0;
        rst3 = 1'b0; en3 = 1'b0; up3 = 1'b0; load3 = 1'b0; lv3 = '0;
        test_reset();
        test_up_wrap();
        test_async_reset();
        test_mod9_up();
        test_mod9_down();
        test_load();
        test_saturate();
        test_done();
        $finish;
    end

    // The done instance ends the run itself, so its final-state checks and the summary live here.
    final begin
        if (done_started) begin
            vectors++; if (edges3 !== 32) begin miscompares++; $display("[TB] FAIL done_edge got %0d expected 32", edges3); end
            vectors++; if (done3 !== 1'b1) begin miscompares++; $display("[TB] FAIL done_flag got %b expected 1", done3); end
            vectors++; if (count3 !== 4'd0 || wraps3 !== 8'd2) begin miscompares++; $display("[TB] FAIL done_state got count %0d wraps %0d expected 0 2", count3, wraps3); end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    end

endmodule
